// File: rtl/arb_pkg.sv
// arb_pkg: shared state/owner encodings and default limits for mem_port_arbiter
package arb_pkg;
   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} arb_state_t;
   typedef enum logic {OWN_IF, OWN_DM} arb_owner_t;
   localparam int STARVE_MAX_DEF = 4;
   localparam int TIMEOUT_DEF    = 16;
endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: cycle counter that flags expiry in the LIMIT-th enabled cycle since the last clear
module arb_watchdog #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);
   localparam int CW = $clog2(LIMIT + 1);
   logic [CW-1:0] r_cnt;
   assign o_expired = i_en && (r_cnt == CW'(LIMIT - 1));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en && !o_expired) r_cnt <= r_cnt + 1'b1;
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data access, DM priority with IF anti-starvation.
// Optional watchdog abort when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = STARVE_MAX_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_valid,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_valid,
   output logic [DW-1:0] dm_rdata,
   output logic          err,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          stall_if,
   output logic          stall_mem
);
   localparam int SW = $clog2(STARVE_MAX + 1);

   if (STARVE_MAX < 1 || TIMEOUT < 1) begin : g_bad_cfg
      $error("mem_port_arbiter: STARVE_MAX and TIMEOUT must be >= 1");
   end

   arb_state_t    r_state, w_next;
   logic [SW-1:0] r_starve_cnt;
   logic          w_if_req, w_dm_req, w_starved, w_if_win, w_dm_win;
   logic          w_busy, w_abort, w_done;

   // the requester whose response is being presented this cycle is not yet re-requesting
   assign w_if_req  = if_req & ~if_valid;
   assign w_dm_req  = dm_req & ~dm_valid;
   assign w_starved = r_starve_cnt == SW'(STARVE_MAX);
   assign w_dm_win  = (r_state == IDLE) & w_dm_req & ~(w_if_req & w_starved);
   assign w_if_win  = (r_state == IDLE) & w_if_req & ~w_dm_win;
   assign w_busy    = r_state != IDLE;
   assign w_done    = w_busy & (mem_ack | w_abort);

   assign mem_en    = w_busy;
   assign stall_if  = if_req & ~if_valid;
   assign stall_mem = dm_req & ~dm_valid;

`ifdef ARB_TIMEOUT_EN
   logic w_expired;
   arb_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
      .clk      (clk),
      .rst_n    (rst),
      .i_clr    (~w_busy),
      .i_en     (w_busy),
      .o_expired(w_expired)
   );
   assign w_abort = w_expired & ~mem_ack;
`else
   assign w_abort = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      if (r_state == IDLE) w_next = w_dm_win ? BUSY_DM : (w_if_win ? BUSY_IF : IDLE);
      else if (w_done) w_next = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_starve_cnt <= '0;
         if_gnt       <= 1'b0;
         dm_gnt       <= 1'b0;
         if_valid     <= 1'b0;
         dm_valid     <= 1'b0;
         if_rdata     <= '0;
         dm_rdata     <= '0;
         err          <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         r_state  <= w_next;
         if_gnt   <= w_if_win;
         dm_gnt   <= w_dm_win;
         if_valid <= w_done & (r_state == BUSY_IF);
         dm_valid <= w_done & (r_state == BUSY_DM);
         err      <= w_busy & w_abort;
         if (r_state == BUSY_IF && mem_ack) if_rdata <= mem_rdata;
         if (r_state == BUSY_DM && mem_ack && !mem_we) dm_rdata <= mem_rdata;
         if (w_dm_win) begin
            mem_addr  <= dm_addr;
            mem_we    <= dm_we;
            mem_wdata <= dm_wdata;
         end else if (w_if_win) begin
            mem_addr  <= if_addr;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
         end
         if (w_if_win) r_starve_cnt <= '0;
         else if (w_dm_win && w_if_req && !w_starved) r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end
endmodule
